// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: iterative 32-bit signed multiply/divide engine with its own
// controller FSM. Works on operand magnitudes (32 shift-add or restoring
// steps), then applies sign correction and loads HI/LO. All outputs are
// registered; DIV by zero short-circuits straight to the completion state.
module mult_div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        hilo_write,
    output logic        div0,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  cnt;
    logic        op_r;
    logic        sign_a;
    logic        sign_b;
    logic        div0_r;

    // MULT: mag_b is the multiplier, shifted right; mcand is the shifted multiplicand.
    // DIV : mag_a is the dividend, shifted left; mag_b is the fixed divisor.
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] mcand;
    logic [63:0] acc;
    logic [31:0] rem;
    logic [31:0] quo;

    logic        accept;
    logic        div_by_zero;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic        rem_ge;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign accept      = start && (state == IDLE);
    assign div_by_zero = op && (b == '0);
    assign abs_a       = a[31] ? (32'd0 - a) : a;
    assign abs_b       = b[31] ? (32'd0 - b) : b;

    // Restoring-divide trial: shift in the next dividend bit, then try to subtract.
    assign rem_shift = {rem, mag_a[31]};
    assign rem_diff  = rem_shift - {1'b0, mag_b};
    assign rem_ge    = (rem_shift >= {1'b0, mag_b});

    // Sign correction: quotient by sign_a^sign_b, remainder follows the dividend.
    assign prod_fix = (sign_a ^ sign_b) ? (64'd0 - acc) : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? (32'd0 - quo) : quo;
    assign rem_fix  = sign_a ? (32'd0 - rem) : rem;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = div_by_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == 5'd31) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and HI/LO result registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            op_r   <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0_r <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            mcand  <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r   <= op;
                        sign_a <= a[31];
                        sign_b <= b[31];
                        div0_r <= div_by_zero;
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        mcand  <= {32'd0, abs_a};
                        cnt    <= '0;
                        acc    <= '0;
                        rem    <= '0;
                        quo    <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    if (!op_r) begin
                        if (mag_b[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand <= mcand << 1;
                        mag_b <= mag_b >> 1;
                    end else begin
                        rem   <= rem_ge ? rem_diff[31:0] : rem_shift[31:0];
                        quo   <= {quo[30:0], rem_ge};
                        mag_a <= mag_a << 1;
                    end
                end
                FIX: begin
                    if (!op_r) begin
                        hi <= prod_fix[63:32];
                        lo <= prod_fix[31:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the current state, so they trail it by one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            hilo_write <= 1'b0;
            div0       <= 1'b0;
        end else begin
            busy       <= (state == RUN) || (state == FIX);
            done       <= (state == DONE);
            hilo_write <= (state == DONE) && !div0_r;
            div0       <= (state == DONE) && div0_r;
        end
    end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Scoreboard testbench for mult_div_ctrl: the driver pushes expected results
// computed with plain signed arithmetic; a monitor pops them on each done.
module tb_mult_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        hilo_write;
    logic        div0;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hilo_write (hilo_write),
        .div0       (div0),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          dcyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        got;
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          active = 1'b0;
    bit          act_dz = 1'b0;
    int          act_e0 = 0;
    logic        busy_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: full-width signed arithmetic; 64-bit division keeps the
    // 0x80000000 / -1 case well defined and its low word is the wrapped quotient.
    task automatic model(input bit o, input logic [31:0] x, input logic [31:0] y,
                         input int e0, output exp_t e);
        longint sx, sy, p, q, r;
        sx = $signed(x);
        sy = $signed(y);
        if (o && y == 32'd0) begin
            e.dz   = 1'b1;
            e.hi   = m_hi;
            e.lo   = m_lo;
            e.dcyc = e0 + 1;
        end else begin
            e.dz = 1'b0;
            if (!o) begin
                p    = sx * sy;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end else begin
                q    = sx / sy;
                r    = sx % sy;
                e.hi = r[31:0];
                e.lo = q[31:0];
            end
            m_hi   = e.hi;
            m_lo   = e.lo;
            e.dcyc = e0 + 34;
        end
    endtask

    task automatic issue(input bit o, input logic [31:0] x, input logic [31:0] y, output int e0);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e0    = cyc + 1;
        model(o, x, y, e0, e);
        sbq.push_back(e);
        act_e0 = e0;
        act_dz = e.dz;
        active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = 1'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout_pending", sbq.size(), 0);
            sbq.delete();
        end
        active = 1'b0;
    endtask

    task automatic run_op(input bit o, input logic [31:0] x, input logic [31:0] y);
        int e0;
        issue(o, x, y, e0);
        wait_done();
    endtask

    // Monitor: every cycle checks busy against the expected window; on done pops the scoreboard.
    always begin
        @(posedge clk);
        #1;
        busy_exp = active && !act_dz && (cyc >= act_e0 + 1) && (cyc <= act_e0 + 33);
        chk("busy", busy, busy_exp);
        if (done) begin
            if (sbq.size() == 0) begin
                chk("done_unexpected", done, 0);
            end else begin
                got = sbq.pop_front();
                chk("hi", hi, got.hi);
                chk("lo", lo, got.lo);
                chk("div0", div0, got.dz);
                chk("hilo_write", hilo_write, !got.dz);
                chk("done_cycle", cyc, got.dcyc);
            end
        end else begin
            chk("div0_without_done", div0, 0);
            chk("hilo_write_without_done", hilo_write, 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    logic [31:0] dir_a [7];
    logic [31:0] dir_b [7];
    bit          dir_op[7];

    initial begin
        int e0;
        int sel;
        logic [31:0] x, y;

        reset = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hilo_write", hilo_write, 0);
        chk("rst_div0", div0, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b1;

        dir_op = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        dir_a  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                   32'h8000_0000, 32'h3333_3333, 32'd123};
        dir_b  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                   32'hFFFF_FFFF, 32'h2222_2222, 32'd0};
        for (int i = 0; i < 7; i++) begin
            run_op(dir_op[i], dir_a[i], dir_b[i]);
        end

        // Second start while busy must be ignored.
        issue(1'b0, 32'd3, 32'd4, e0);
        while (cyc < e0 + 4) @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'd55;
        b     = 32'd0;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);

        // Reset sampled at E10 of a DIV aborts it with everything cleared.
        issue(1'b1, 32'd100, 32'd7, e0);
        while (cyc < e0 + 9) @(negedge clk);
        reset  = 1'b0;
        active = 1'b0;
        sbq.delete();
        m_hi   = '0;
        m_lo   = '0;
        @(negedge clk);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        run_op(1'b1, 32'd100, 32'd7);

        // Randomised operations, biased toward edge-case divisors/multipliers.
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 5));
            x = $urandom;
            y = $urandom;
            case (sel)
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 15));
                3: x = 32'h8000_0000;
                default: ;
            endcase
            run_op(1'($urandom), x, y);
        end

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
